// File: rtl/decode_if.sv
// Fetch-to-decode handshake plus the registered ex-stage control bundle.
// The counter preset lets a fetch/debug agent load issue_count directly.
interface decode_if #(
  parameter int unsigned XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_insn;
  logic [XLEN-1:0] in_pc;
  logic            cnt_set;
  logic [31:0]     cnt_set_val;

  logic            insn30;
  logic [2:0]      funct3;
  logic            w;
  logic            fwd1;
  logic            fwd2;
  logic            imm1;
  logic            imm2;
  logic [XLEN-1:0] imm1val;
  logic [XLEN-1:0] imm2val;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic            halted;
  logic [31:0]     issue_count;

  modport master (
    output in_valid, in_insn, in_pc, cnt_set, cnt_set_val,
    input  in_ready, insn30, funct3, w, fwd1, fwd2, imm1, imm2, imm1val, imm2val,
    input  rs1, rs2, rd, halted, issue_count
  );

  modport slave (
    input  in_valid, in_insn, in_pc, cnt_set, cnt_set_val,
    output in_ready, insn30, funct3, w, fwd1, fwd2, imm1, imm2, imm1val, imm2val,
    output rs1, rs2, rd, halted, issue_count
  );
endinterface

// File: rtl/decode.sv
// RV integer ALU decode stage: registered ex controls, distance-1 forwarding flags,
// sticky halt on illegal instructions and a wrapping issue counter.
module decode #(
  parameter int unsigned XLEN = 64
) (
  input logic     clock,
  input logic     reset_n,
  decode_if.slave bus
);
  typedef enum logic {StRun, StHalt} state_e;

  localparam logic [6:0] OpcOp      = 7'b0110011;
  localparam logic [6:0] OpcOpImm   = 7'b0010011;
  localparam logic [6:0] OpcOp32    = 7'b0111011;
  localparam logic [6:0] OpcOpImm32 = 7'b0011011;
  localparam logic [6:0] OpcLui     = 7'b0110111;
  localparam logic [6:0] OpcAuipc   = 7'b0010111;

  state_e          r_state;
  logic            r_insn30, r_w, r_fwd1, r_fwd2, r_imm1, r_imm2, r_halted;
  logic [2:0]      r_funct3;
  logic [XLEN-1:0] r_imm1val, r_imm2val;
  logic [4:0]      r_rs1, r_rs2, r_rd;
  logic [31:0]     r_issue_count;

  logic [31:0]     w_insn;
  logic [6:0]      w_opc;
  logic [63:0]     w_iimm, w_uimm;
  logic            w_xfer, w_legal;
  logic            w_insn30, w_w, w_fwd1, w_fwd2, w_imm1, w_imm2;
  logic [2:0]      w_funct3;
  logic [XLEN-1:0] w_imm1val, w_imm2val;
  logic [4:0]      w_rs1, w_rs2, w_rd;

  assign w_insn = bus.in_insn;
  assign w_opc  = w_insn[6:0];
  assign w_iimm = {{52{w_insn[31]}}, w_insn[31:20]};
  assign w_uimm = {{32{w_insn[31]}}, w_insn[31:12], 12'h000};
  assign bus.in_ready = reset_n && (r_state == StRun);
  assign w_xfer = bus.in_valid && bus.in_ready;

  always_comb begin
    w_legal   = 1'b0;
    w_insn30  = 1'b0;
    w_w       = 1'b0;
    w_funct3  = w_insn[14:12];
    w_rs1     = w_insn[19:15];
    w_rs2     = w_insn[24:20];
    w_rd      = w_insn[11:7];
    w_imm1    = 1'b0;
    w_imm2    = 1'b0;
    w_imm1val = '0;
    w_imm2val = '0;
    case (w_opc)
      OpcOp, OpcOp32: begin
        w_legal  = (w_opc == OpcOp) || (XLEN == 64);
        w_w      = (w_opc == OpcOp32);
        w_insn30 = w_insn[30];
      end
      OpcOpImm, OpcOpImm32: begin
        w_legal   = (w_opc == OpcOpImm) || (XLEN == 64);
        w_w       = (w_opc == OpcOpImm32);
        w_insn30  = (w_funct3 == 3'b101) && w_insn[30];
        w_rs2     = '0;
        w_imm2    = 1'b1;
        w_imm2val = w_iimm[XLEN-1:0];
      end
      OpcLui, OpcAuipc: begin
        w_legal   = 1'b1;
        w_funct3  = '0;
        w_rs1     = '0;
        w_rs2     = '0;
        w_imm1    = 1'b1;
        w_imm2    = 1'b1;
        w_imm2val = w_uimm[XLEN-1:0];
        if (w_opc == OpcAuipc) w_imm1val = bus.in_pc;
      end
      default: ;
    endcase
    // x0 sources become a zero immediate so ex never reads the register file for them.
    if (w_rs1 == 5'd0) w_imm1 = 1'b1;
    if (w_rs2 == 5'd0) w_imm2 = 1'b1;
    // r_rd is the rd currently presented; bubbles present rd=0 and so never match.
    w_fwd1 = (r_rd != 5'd0) && (r_rd == w_rs1);
    w_fwd2 = (r_rd != 5'd0) && (r_rd == w_rs2);
    if (w_fwd1) w_imm1 = 1'b0;
    if (w_fwd2) w_imm2 = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= StRun;
      r_halted      <= 1'b0;
      r_issue_count <= '0;
      r_insn30      <= 1'b0;
      r_funct3      <= '0;
      r_w           <= 1'b0;
      r_fwd1        <= 1'b0;
      r_fwd2        <= 1'b0;
      r_imm1        <= 1'b1;
      r_imm2        <= 1'b1;
      r_imm1val     <= '0;
      r_imm2val     <= '0;
      r_rs1         <= '0;
      r_rs2         <= '0;
      r_rd          <= '0;
    end else begin
      r_insn30  <= 1'b0;
      r_funct3  <= '0;
      r_w       <= 1'b0;
      r_fwd1    <= 1'b0;
      r_fwd2    <= 1'b0;
      r_imm1    <= 1'b1;
      r_imm2    <= 1'b1;
      r_imm1val <= '0;
      r_imm2val <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_rd      <= '0;
      if (w_xfer && w_legal) begin
        r_insn30  <= w_insn30;
        r_funct3  <= w_funct3;
        r_w       <= w_w;
        r_fwd1    <= w_fwd1;
        r_fwd2    <= w_fwd2;
        r_imm1    <= w_imm1;
        r_imm2    <= w_imm2;
        r_imm1val <= w_imm1val;
        r_imm2val <= w_imm2val;
        r_rs1     <= w_rs1;
        r_rs2     <= w_rs2;
        r_rd      <= w_rd;
      end
      if (w_xfer && !w_legal) begin
        r_state  <= StHalt;
        r_halted <= 1'b1;
      end
      if (bus.cnt_set) begin
        r_issue_count <= bus.cnt_set_val;
      end else if (w_xfer && w_legal) begin
        r_issue_count <= r_issue_count + 32'd1;
      end
    end
  end

  assign bus.insn30      = r_insn30;
  assign bus.funct3      = r_funct3;
  assign bus.w           = r_w;
  assign bus.fwd1        = r_fwd1;
  assign bus.fwd2        = r_fwd2;
  assign bus.imm1        = r_imm1;
  assign bus.imm2        = r_imm2;
  assign bus.imm1val     = r_imm1val;
  assign bus.imm2val     = r_imm2val;
  assign bus.rs1         = r_rs1;
  assign bus.rs2         = r_rs2;
  assign bus.rd          = r_rd;
  assign bus.halted      = r_halted;
  assign bus.issue_count = r_issue_count;
endmodule

// File: tb/tb_decode.sv
// Bench for decode: XLEN=64 and XLEN=32 instances side by side, directed cases plus
// random instruction streams checked against an instruction-level reference model.
module tb_decode;
  typedef struct packed {
    logic        insn30;
    logic [2:0]  funct3;
    logic        w;
    logic        fwd1;
    logic        fwd2;
    logic        imm1;
    logic        imm2;
    logic [63:0] imm1val;
    logic [63:0] imm2val;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } ex_t;

  logic        clock = 1'b0;
  logic        reset_n;
  int          total = 0;
  int          bad = 0;
  logic [31:0] c64 = 0;
  logic [31:0] c32 = 0;

  always #5 clock = ~clock;

  decode_if #(.XLEN(64)) b64 ();
  decode_if #(.XLEN(32)) b32 ();

  decode #(.XLEN(64)) u_dut64 (.clock(clock), .reset_n(reset_n), .bus(b64));
  decode #(.XLEN(32)) u_dut32 (.clock(clock), .reset_n(reset_n), .bus(b32));

  function automatic ex_t bubble();
    ex_t e;
    e = '0;
    e.imm1 = 1'b1;
    e.imm2 = 1'b1;
    return e;
  endfunction

  function automatic ex_t get64();
    ex_t g;
    g = '{insn30: b64.insn30, funct3: b64.funct3, w: b64.w, fwd1: b64.fwd1, fwd2: b64.fwd2,
          imm1: b64.imm1, imm2: b64.imm2, imm1val: b64.imm1val, imm2val: b64.imm2val,
          rs1: b64.rs1, rs2: b64.rs2, rd: b64.rd};
    return g;
  endfunction

  function automatic ex_t get32();
    ex_t g;
    g = '{insn30: b32.insn30, funct3: b32.funct3, w: b32.w, fwd1: b32.fwd1, fwd2: b32.fwd2,
          imm1: b32.imm1, imm2: b32.imm2, imm1val: {32'h0, b32.imm1val},
          imm2val: {32'h0, b32.imm2val}, rs1: b32.rs1, rs2: b32.rs2, rd: b32.rd};
    return g;
  endfunction

  // Instruction-level reference: what ex should see for insn, given the rd presented before it.
  function automatic ex_t ref_decode(input logic [31:0] insn, input logic [63:0] pc,
                                     input int xlen, input logic [4:0] prev_rd,
                                     output bit legal);
    ex_t        e;
    int         si;
    logic [6:0] opc;
    bit         is_reg, is_imm, is_u, is_w;
    e = bubble();
    opc = insn[6:0];
    is_w   = (opc == 7'h3B) || (opc == 7'h1B);
    is_reg = (opc == 7'h33) || (opc == 7'h3B);
    is_imm = (opc == 7'h13) || (opc == 7'h1B);
    is_u   = (opc == 7'h37) || (opc == 7'h17);
    legal  = (is_reg || is_imm || is_u) && !(is_w && xlen == 32);
    if (!legal) return e;
    e.rd = insn[11:7];
    e.w  = is_w;
    if (is_u) begin
      si = $signed({insn[31:12], 12'h000});
      e.imm1val = (opc == 7'h17) ? pc : 64'h0;
      e.imm2val = longint'(si);
    end else begin
      e.funct3 = insn[14:12];
      e.rs1    = insn[19:15];
      e.imm1   = (e.rs1 == 5'd0);
      if (is_reg) begin
        e.rs2    = insn[24:20];
        e.imm2   = (e.rs2 == 5'd0);
        e.insn30 = insn[30];
      end else begin
        si = $signed(insn);
        e.imm2val = longint'(si >>> 20);
        e.insn30  = (insn[14:12] == 3'd5) && insn[30];
      end
    end
    e.fwd1 = (prev_rd != 5'd0) && (prev_rd == e.rs1);
    e.fwd2 = (prev_rd != 5'd0) && (prev_rd == e.rs2);
    if (e.fwd1) e.imm1 = 1'b0;
    if (e.fwd2) e.imm2 = 1'b0;
    if (xlen == 32) begin
      e.imm1val[63:32] = '0;
      e.imm2val[63:32] = '0;
    end
    return e;
  endfunction

  function automatic logic [31:0] r_insn(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] rand_insn(input bit allow_w);
    logic [6:0]  opcs [6];
    logic [31:0] r;
    opcs = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h3B, 7'h1B};
    r = $urandom;
    return {r[31:25], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), r[14:12],
            5'($urandom_range(0, 7)), opcs[$urandom_range(0, allow_w ? 5 : 3)]};
  endfunction

  task automatic drive(input bit v64, input logic [31:0] i64, input bit v32,
                       input logic [31:0] i32, input logic [63:0] pc);
    b64.in_valid = v64;
    b64.in_insn  = i64;
    b64.in_pc    = pc;
    b32.in_valid = v32;
    b32.in_insn  = i32;
    b32.in_pc    = pc[31:0];
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 64'h0);
    @(negedge clock);
    reset_n = 1'b1;
    c64 = 0;
    c32 = 0;
  endtask

  task automatic test_reset();
    ex_t e;
    reset_n = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 64'h0);
    b64.cnt_set = 1'b0; b64.cnt_set_val = '0;
    b32.cnt_set = 1'b0; b32.cnt_set_val = '0;
    #1 reset_n = 1'b0;
    @(negedge clock);
    e = get64();
    total++;
    if (e !== bubble()) begin bad++; $display("FAIL reset_bubble got=%h exp=%h", e, bubble()); end
    total++;
    if (b64.in_ready !== 1'b0 || b32.in_ready !== 1'b0) begin
      bad++; $display("FAIL reset_ready got=%b%b exp=00", b64.in_ready, b32.in_ready);
    end
    total++;
    if (b64.halted !== 1'b0 || b64.issue_count !== 32'h0) begin
      bad++; $display("FAIL reset_state halted=%b count=%h exp=0/0", b64.halted, b64.issue_count);
    end
    reset_n = 1'b1;
    #1;
    total++;
    if (b64.in_ready !== 1'b1 || b32.in_ready !== 1'b1) begin
      bad++; $display("FAIL ready_after_reset got=%b%b exp=11", b64.in_ready, b32.in_ready);
    end
    @(negedge clock);
  endtask

  task automatic test_directed();
    ex_t         e;
    logic [31:0] i;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 64'h0);
    @(negedge clock);
    // ADD x3,x1,x2 then SUB x4,x3,x1
    i = r_insn(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33);
    drive(1'b1, i, 1'b1, i, 64'h0);
    @(negedge clock);
    c64++; c32++;
    e = bubble(); e.imm1 = 0; e.imm2 = 0; e.rs1 = 1; e.rs2 = 2; e.rd = 3;
    total++;
    if (get64() !== e) begin bad++; $display("FAIL add got=%h exp=%h", get64(), e); end
    i = r_insn(7'h20, 5'd1, 5'd3, 3'd0, 5'd4, 7'h33);
    drive(1'b1, i, 1'b1, i, 64'h0);
    @(negedge clock);
    c64++; c32++;
    e = bubble(); e.imm1 = 0; e.imm2 = 0; e.rs1 = 3; e.rs2 = 1; e.rd = 4;
    e.insn30 = 1; e.fwd1 = 1;
    total++;
    if (get64() !== e) begin bad++; $display("FAIL sub_fwd got=%h exp=%h", get64(), e); end
    // ADDI x5,x0,-1
    i = {12'hFFF, 5'd0, 3'd0, 5'd5, 7'h13};
    drive(1'b1, i, 1'b1, i, 64'h0);
    @(negedge clock);
    c64++; c32++;
    e = bubble(); e.imm2val = '1; e.rd = 5;
    total++;
    if (get64() !== e) begin bad++; $display("FAIL addi got=%h exp=%h", get64(), e); end
    e.imm2val = 64'hFFFF_FFFF;
    total++;
    if (get32() !== e) begin bad++; $display("FAIL addi32 got=%h exp=%h", get32(), e); end
    // ADD x3,..; idle; ADD x6,x3,x3
    i = r_insn(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33);
    drive(1'b1, i, 1'b1, i, 64'h0);
    @(negedge clock);
    c64++; c32++;
    drive(1'b0, i, 1'b0, i, 64'h0);
    @(negedge clock);
    total++;
    if (get64() !== bubble()) begin bad++; $display("FAIL idle got=%h exp=%h", get64(), bubble()); end
    i = r_insn(7'h00, 5'd3, 5'd3, 3'd0, 5'd6, 7'h33);
    drive(1'b1, i, 1'b1, i, 64'h0);
    @(negedge clock);
    c64++; c32++;
    e = bubble(); e.imm1 = 0; e.imm2 = 0; e.rs1 = 3; e.rs2 = 3; e.rd = 6;
    total++;
    if (get64() !== e) begin bad++; $display("FAIL dist2 got=%h exp=%h", get64(), e); end
    // AUIPC x7,0x12345 at pc 0x1000
    i = {20'h12345, 5'd7, 7'h17};
    drive(1'b1, i, 1'b1, i, 64'h1000);
    @(negedge clock);
    c64++; c32++;
    e = bubble(); e.imm1val = 64'h1000; e.imm2val = 64'h1234_5000; e.rd = 7;
    total++;
    if (get64() !== e) begin bad++; $display("FAIL auipc got=%h exp=%h", get64(), e); end
    total++;
    if (get32() !== e) begin bad++; $display("FAIL auipc32 got=%h exp=%h", get32(), e); end
    total++;
    if (b64.issue_count !== c64) begin
      bad++; $display("FAIL dir_count got=%h exp=%h", b64.issue_count, c64);
    end
  endtask

  // Random back-to-back stream; W ops only on the 64-bit instance.
  task automatic test_random();
    ex_t         e64, e32;
    logic [4:0]  p64, p32;
    logic [31:0] i64, i32;
    logic [63:0] pc;
    bit          v, l64, l32;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 64'h0);
    @(negedge clock);
    p64 = 0; p32 = 0;
    for (int n = 0; n < 400; n++) begin
      v   = ($urandom_range(0, 5) != 0);
      i64 = rand_insn(1'b1);
      i32 = rand_insn(1'b0);
      pc  = {$urandom, $urandom} & ~64'h3;
      drive(v, i64, v, i32, pc);
      e64 = bubble(); e32 = bubble(); l64 = 0; l32 = 0;
      if (v) begin
        e64 = ref_decode(i64, pc, 64, p64, l64);
        e32 = ref_decode(i32, pc, 32, p32, l32);
      end
      if (l64) c64++;
      if (l32) c32++;
      @(negedge clock);
      total++;
      if (get64() !== e64) begin bad++; $display("FAIL rand64 n=%0d got=%h exp=%h", n, get64(), e64); end
      total++;
      if (get32() !== e32) begin bad++; $display("FAIL rand32 n=%0d got=%h exp=%h", n, get32(), e32); end
      total++;
      if (b64.issue_count !== c64 || b32.issue_count !== c32 || b64.in_ready !== 1'b1) begin
        bad++;
        $display("FAIL rand_count n=%0d got=%h/%h rdy=%b exp=%h/%h rdy=1", n, b64.issue_count,
                 b32.issue_count, b64.in_ready, c64, c32);
      end
      p64 = e64.rd;
      p32 = e32.rd;
    end
  endtask

  task automatic test_w_and_halt();
    ex_t         e;
    logic [31:0] i;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 64'h0);
    @(negedge clock);
    // ADDW x1,x2,x3
    i = r_insn(7'h00, 5'd3, 5'd2, 3'd0, 5'd1, 7'h3B);
    drive(1'b1, i, 1'b1, i, 64'h0);
    @(negedge clock);
    c64++;
    e = bubble(); e.imm1 = 0; e.imm2 = 0; e.rs1 = 2; e.rs2 = 3; e.rd = 1; e.w = 1;
    total++;
    if (get64() !== e) begin bad++; $display("FAIL addw64 got=%h exp=%h", get64(), e); end
    total++;
    if (get32() !== bubble() || b32.halted !== 1'b1 || b32.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL addw32 got=%h halted=%b rdy=%b exp=bubble/1/0", get32(), b32.halted,
               b32.in_ready);
    end
    // Halted instance ignores further legal traffic.
    i = r_insn(7'h00, 5'd1, 5'd1, 3'd0, 5'd2, 7'h33);
    drive(1'b1, i, 1'b1, i, 64'h0);
    @(negedge clock);
    c64++;
    total++;
    if (get32() !== bubble() || b32.issue_count !== c32 || b32.halted !== 1'b1) begin
      bad++;
      $display("FAIL halt32 got=%h count=%h exp=bubble count=%h", get32(), b32.issue_count, c32);
    end
    // insn[1:0] != 11 on the 64-bit instance
    drive(1'b1, 32'h0000_0032, 1'b0, 32'h0, 64'h0);
    @(negedge clock);
    total++;
    if (get64() !== bubble() || b64.halted !== 1'b1 || b64.in_ready !== 1'b0 ||
        b64.issue_count !== c64) begin
      bad++;
      $display("FAIL illegal64 got=%h halted=%b rdy=%b count=%h exp_count=%h", get64(),
               b64.halted, b64.in_ready, b64.issue_count, c64);
    end
  endtask

  task automatic test_wrap_and_reset();
    ex_t         e;
    logic [31:0] i;
    pulse_reset();
    b64.cnt_set = 1'b1;
    b64.cnt_set_val = 32'hFFFF_FFFE;
    @(negedge clock);
    b64.cnt_set = 1'b0;
    i = r_insn(7'h00, 5'd2, 5'd1, 3'd0, 5'd9, 7'h33);
    drive(1'b1, i, 1'b1, i, 64'h0);
    @(negedge clock);
    total++;
    if (b64.issue_count !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL wrap_pre got=%h exp=ffffffff", b64.issue_count);
    end
    @(negedge clock);
    total++;
    if (b64.issue_count !== 32'h0) begin
      bad++; $display("FAIL wrap got=%h exp=00000000", b64.issue_count);
    end
    // Reset mid-stream, away from any clock edge.
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (get64() !== bubble() || b64.issue_count !== 32'h0 || b64.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL midreset got=%h count=%h rdy=%b exp=%h/0/0", get64(), b64.issue_count,
               b64.in_ready, bubble());
    end
    @(negedge clock);
    reset_n = 1'b1;
    i = r_insn(7'h00, 5'd9, 5'd9, 3'd0, 5'd10, 7'h33);
    drive(1'b1, i, 1'b1, i, 64'h0);
    @(negedge clock);
    e = bubble(); e.imm1 = 0; e.imm2 = 0; e.rs1 = 9; e.rs2 = 9; e.rd = 10;
    total++;
    if (get64() !== e || b64.issue_count !== 32'd1) begin
      bad++;
      $display("FAIL post_reset got=%h count=%h exp=%h count=1", get64(), b64.issue_count, e);
    end
    drive(1'b0, 32'h0, 1'b0, 32'h0, 64'h0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_w_and_halt();
    test_wrap_and_reset();
    @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/decode.md
DECODE -- requirements
Module: decode

Interface
REQ-001 Parameter XLEN, default 64, datapath width; 32 or 64 only.
REQ-002 clock  in  1  single clock; all state updates on rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 in_valid  in  1  fetch presents an instruction.
REQ-005 in_ready  out  1  decode accepts; transfer occurs when in_valid&&in_ready at a rising edge.
REQ-006 in_insn  in  32  RV instruction word.
REQ-007 in_pc  in  XLEN  address of in_insn.
REQ-008 insn30, funct3[2:0], w, fwd1, fwd2, imm1, imm2  out  registered ex-stage controls.
REQ-009 imm1val, imm2val  out  XLEN  registered operand immediates.
REQ-010 rs1, rs2, rd  out  5 each  registered register indices.
REQ-011 halted  out  1  sticky: illegal instruction seen.
REQ-012 issue_count  out  32  count of non-bubble instructions issued.

Function
REQ-013 FSM states: RUN, HALT; reset enters RUN.
REQ-014 in_ready SHALL be 1 in RUN, 0 in HALT and while reset_n is low.
REQ-015 All ex-facing outputs SHALL be registered; one cycle latency from acceptance to presentation.
REQ-016 Cycle with no transfer SHALL present a bubble: funct3=0, insn30=0, w=0, imm1=imm2=1, imm1val=imm2val=0, rd=0, rs1=rs2=0, fwd1=fwd2=0.
REQ-017 OP (0110011): funct3, insn30=insn[30], rs1, rs2, rd from fields, imm1=imm2=0, w=0.
REQ-018 OP-IMM (0010011): imm2=1, imm2val=sign-extended I-imm; insn30=insn[30] only when funct3=101, else 0.
REQ-019 OP-32 (0111011)/OP-IMM-32 (0011011): as REQ-017/018 with w=1; illegal when XLEN=32.
REQ-020 LUI: funct3=0, imm1=1 imm1val=0, imm2=1 imm2val=sign-extended U-imm (insn[31:12]<<12).
REQ-021 AUIPC: as LUI but imm1val=in_pc.
REQ-022 Any source index equal to 0 SHALL be issued as imm=1, immval=0 (x0 reads never use rf).
REQ-023 fwdN=1 iff the instruction presented in the immediately preceding cycle was non-bubble, had rd!=0, and its rd equals this instruction's rsN (N=1,2); fwdN overrides immN.
REQ-024 Bubbles and rd=0 instructions SHALL never cause forwarding; distance-2 dependencies SHALL NOT forward.
REQ-025 Any other opcode, or insn[1:0]!=11, is illegal: present bubble, do not count, enter HALT next edge, halted=1.
REQ-026 HALT persists until reset; only bubbles issued.
REQ-027 issue_count increments by 1 per non-bubble issue, wraps 2^32-1 -> 0.
REQ-028 Back-to-back transfers every cycle SHALL be sustained in RUN without stall.

Reset
REQ-029 Asserting reset_n low SHALL immediately, mid-operation, force the bubble on all ex-facing outputs, halted=0, issue_count=0, last-rd tracking cleared, state RUN.
REQ-030 First transfer possible on first rising edge after reset_n deasserts; no forwarding to pre-reset instructions.

Verification
REQ-031 ADD x3,x1,x2 then SUB x4,x3,x1 back-to-back -> second issue: fwd1=1, fwd2=0, insn30=1, rd=4.
REQ-032 ADDI x5,x0,-1 -> imm1=1 imm1val=0, imm2=1 imm2val=all-ones, rd=5, insn30=0.
REQ-033 ADD x3,..; idle cycle; ADD x6,x3,x3 -> fwd1=fwd2=0 (bubble between).
REQ-034 ADDW x1,x2,x3 with XLEN=64 -> w=1; with XLEN=32 -> bubble, halted=1, in_ready=0 next cycle, issue_count unchanged.
REQ-035 AUIPC x7,0x12345 at pc=0x1000 -> imm1val=0x1000, imm2val=0x12345000, funct3=0.
REQ-036 issue_count preset near 0xFFFFFFFF by 1 issue wraps to 0; reset_n pulse mid-stream -> bubble outputs immediately, issue_count=0.
